i2c_eeprom_slave: RTL

//   I2C target that emulates a 24Cxx-style EEPROM: 7-bit device address, 2-byte word address,

---
 rtl/i2c_eeprom_slave.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_eeprom_slave.sv
// I2C target emulating a 24Cxx-style EEPROM with a 2-byte word address.
// SCL/SDA are oversampled on sys_clk; SDA is driven open-drain (0 or z only).
module i2c_eeprom_slave #(
    parameter logic [6:0] DEVICE_ADDR  = 7'b1010_000,
    parameter int         MEM_AW       = 8,
    parameter int         SYS_CLK_FREQ = 50_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              i2c_scl,
    inout  wire               i2c_sda,
    output logic              wr_pulse,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [7:0]        wr_byte,
    output logic              busy
);

    // Four sys_clk per SCL phase at 100 kHz needs at least 800 kHz.
    if (SYS_CLK_FREQ < 800_000) begin : g_clk_too_slow
        $error("i2c_eeprom_slave: SYS_CLK_FREQ too low to oversample SCL");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_ACK_DEV, S_ADDR_H, S_ACK_H, S_ADDR_L, S_ACK_L,
        S_WR_BYTE, S_ACK_WR, S_RD_BYTE, S_RD_MACK
    } state_e;

    logic [1:0]        scl_sync_q, sda_sync_q;
    logic              scl_dly_q, sda_dly_q;
    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              phase_q, phase_d;
    logic [6:0]        shift_q, shift_d;
    logic [6:0]        rd_shift_q, rd_shift_d;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic [MEM_AW-1:0] ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic              sda_oe_q, sda_oe_d;
    logic              wr_pulse_q, wr_pulse_d;
    logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_byte_q, wr_byte_d;
    logic              busy_q, busy_d;
    logic [7:0]        mem [2**MEM_AW];

    logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0] byte_s, rd_byte_s;

    assign scl_s      = scl_sync_q[1];
    assign sda_s      = sda_sync_q[1];
    assign scl_rise_s = scl_s & ~scl_dly_q;
    assign scl_fall_s = ~scl_s & scl_dly_q;
    assign start_s    = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
    assign stop_s     = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
    assign byte_s     = {shift_q, sda_s};
    assign rd_byte_s  = mem[ptr_q];

    assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign wr_byte  = wr_byte_q;
    assign busy     = busy_q;

    // Two-stage synchronisers plus one delayed copy for edge detection; reset to idle-bus level.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i2c_scl};
            sda_sync_q <= {sda_sync_q[0], i2c_sda};
            scl_dly_q  <= scl_s;
            sda_dly_q  <= sda_s;
        end
    end

    // Next-state logic; START/STOP take priority over any byte in progress.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        phase_d    = phase_q;
        shift_d    = shift_q;
        rd_shift_d = rd_shift_q;
        addr_hi_d  = addr_hi_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_byte_d  = wr_byte_q;
        busy_d     = busy_q;
        if (start_s) begin
            state_d   = S_DEV_ADDR;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
        end else if (stop_s) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
                S_DEV_ADDR, S_ADDR_H, S_ADDR_L, S_WR_BYTE: begin
                    if (scl_rise_s) begin
                        shift_d   = byte_s[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            case (state_q)
                                S_DEV_ADDR: begin
                                    if (byte_s[7:1] == DEVICE_ADDR) begin
                                        rw_d    = byte_s[0];
                                        busy_d  = 1'b1;
                                        state_d = S_ACK_DEV;
                                    end else begin
                                        busy_d  = 1'b0;
                                        state_d = S_IDLE;
                                    end
                                end
                                S_ADDR_H: begin
                                    addr_hi_d = byte_s;
                                    state_d   = S_ACK_H;
                                end
                                S_ADDR_L: begin
                                    ptr_d   = MEM_AW'({addr_hi_q, byte_s});
                                    state_d = S_ACK_L;
                                end
                                S_WR_BYTE: begin
                                    wr_pulse_d = 1'b1;
                                    wr_addr_d  = ptr_q;
                                    wr_byte_d  = byte_s;
                                    ptr_d      = ptr_q + MEM_AW'(1);
                                    state_d    = S_ACK_WR;
                                end
                                default: state_d = S_IDLE;
                            endcase
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                S_ACK_DEV, S_ACK_H, S_ACK_L, S_ACK_WR: begin
                    // phase_q: 0 = waiting for the fall that opens the ACK slot, 1 = ACK driven.
                    if (scl_fall_s && !phase_q) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b1;
                    end else if (scl_fall_s) begin
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd0;
                        sda_oe_d  = 1'b0;
                        case (state_q)
                            S_ACK_DEV: begin
                                if (rw_q) begin
                                    rd_shift_d = rd_byte_s[6:0];
                                    sda_oe_d   = ~rd_byte_s[7];
                                    state_d    = S_RD_BYTE;
                                end else begin
                                    state_d = S_ADDR_H;
                                end
                            end
                            S_ACK_H: state_d = S_ADDR_L;
                            default: state_d = S_WR_BYTE;
                        endcase
                    end else begin
                        state_d = state_q;
                    end
                end
                S_RD_BYTE: begin
                    if (scl_rise_s) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        phase_d   = (bit_cnt_q == 3'd7);
                    end else if (scl_fall_s && phase_q) begin
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                        state_d  = S_RD_MACK;
                    end else if (scl_fall_s) begin
                        sda_oe_d   = ~rd_shift_q[6];
                        rd_shift_d = {rd_shift_q[5:0], 1'b1};
                    end else begin
                        state_d = state_q;
                    end
                end
                S_RD_MACK: begin
                    if (scl_rise_s && !phase_q) begin
                        if (!sda_s) begin
                            ptr_d   = ptr_q + MEM_AW'(1);
                            phase_d = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                    end else if (scl_fall_s && phase_q) begin
                        phase_d    = 1'b0;
                        bit_cnt_d  = 3'd0;
                        rd_shift_d = rd_byte_s[6:0];
                        sda_oe_d   = ~rd_byte_s[7];
                        state_d    = S_RD_BYTE;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // FSM and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            phase_q    <= 1'b0;
            shift_q    <= 7'd0;
            rd_shift_q <= 7'd0;
            addr_hi_q  <= 8'd0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_byte_q  <= 8'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            phase_q    <= phase_d;
            shift_q    <= shift_d;
            rd_shift_q <= rd_shift_d;
            addr_hi_q  <= addr_hi_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_byte_q  <= wr_byte_d;
            busy_q     <= busy_d;
        end
    end

    // Memory array; contents deliberately survive reset.
    always_ff @(posedge sys_clk) begin
        if (wr_pulse_d) begin
            mem[wr_addr_d] <= wr_byte_d;
        end
    end

endmodule
